program_loader: RTL and testbench

Writer side of the processor's 16-entry instruction memory, which the 4-bit program counter reads.
- Accepts a framed byte stream over a valid/ready handshake: header, N instruction bytes, checksum.
- Writes the instruction bytes to memory addresses 0..N-1.
- Holds the CPU in reset until a load completes with a good checksum; on success, releases the CPU so the PC starts fetching at address 0.

---
 rtl/program_loader_if.sv | 35 +++
 rtl/program_loader.sv | 129 ++++++++++++
 tb/tb_program_loader.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | program_loader_if : stream, memory-write and status bundle        |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
interface program_loader_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) ();
  logic                  start;
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  cpu_reset;
  logic                  busy;
  logic                  done;
  logic                  checksum_err;
  logic [ADDR_WIDTH:0]   word_count;

  modport master (
    output start, in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata, cpu_reset, busy, done,
           checksum_err, word_count
  );

  modport slave (
    input  start, in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata, cpu_reset, busy, done,
           checksum_err, word_count
  );
endinterface
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// +------------------------------------------------------------------+
// | program_loader : framed byte-stream writer for instruction memory |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module program_loader #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  wire logic       clk,
  input  wire logic       reset,
  program_loader_if.slave bus
);
  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] c_DEPTH = CW'(2 ** ADDR_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_DATA = 3'd2,
    S_CHK  = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [CW-1:0]         r_count, w_count_nxt;
  logic [CW-1:0]         r_n, w_n_nxt;
  logic [DATA_WIDTH-1:0] r_sum, w_sum_nxt;
  logic                  r_we, w_we_nxt;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
  logic [DATA_WIDTH-1:0] r_wdata, w_wdata_nxt;
  logic                  r_busy, r_done, r_err, r_cpu_reset;

  logic                  w_accept;
  logic [CW-1:0]         w_hdr_n;
  logic                  w_hdr_ok;
  logic [DATA_WIDTH-1:0] w_chk_sum;

  // r_busy doubles as in_ready: bytes are only taken in HDR, DATA and CHK
  assign w_accept  = bus.in_valid && r_busy;
  assign w_hdr_n   = bus.in_data[ADDR_WIDTH:0];
  assign w_hdr_ok  = ((bus.in_data >> CW) == '0) && (w_hdr_n != '0) && (w_hdr_n <= c_DEPTH);
  assign w_chk_sum = r_sum + bus.in_data;

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_n_nxt     = r_n;
    w_sum_nxt   = r_sum;
    w_we_nxt    = 1'b0;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (bus.start) begin
          w_state_nxt = S_HDR;
          w_count_nxt = '0;
          w_n_nxt     = '0;
          w_sum_nxt   = '0;
        end
      end
      S_HDR: begin
        if (w_accept) begin
          w_n_nxt     = w_hdr_n;
          w_state_nxt = w_hdr_ok ? S_DATA : S_ERR;
        end
      end
      S_DATA: begin
        if (w_accept) begin
          w_we_nxt    = 1'b1;
          w_addr_nxt  = r_count[ADDR_WIDTH-1:0];
          w_wdata_nxt = bus.in_data;
          w_count_nxt = r_count + CW'(1);
          w_sum_nxt   = w_chk_sum;
          if (w_count_nxt == r_n) begin
            w_state_nxt = S_CHK;
          end
        end
      end
      S_CHK: begin
        if (w_accept) begin
          w_state_nxt = (w_chk_sum == '0) ? S_DONE : S_ERR;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Status flags are registered from the next state so they move with it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_n         <= '0;
      r_sum       <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_cpu_reset <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_count     <= w_count_nxt;
      r_n         <= w_n_nxt;
      r_sum       <= w_sum_nxt;
      r_we        <= w_we_nxt;
      r_addr      <= w_addr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_busy      <= (w_state_nxt == S_HDR) || (w_state_nxt == S_DATA) || (w_state_nxt == S_CHK);
      r_done      <= (w_state_nxt == S_DONE);
      r_err       <= (w_state_nxt == S_ERR);
      r_cpu_reset <= (w_state_nxt != S_DONE);
    end
  end

  assign bus.in_ready     = r_busy;
  assign bus.busy         = r_busy;
  assign bus.mem_we       = r_we;
  assign bus.mem_addr     = r_addr;
  assign bus.mem_wdata    = r_wdata;
  assign bus.done         = r_done;
  assign bus.checksum_err = r_err;
  assign bus.cpu_reset    = r_cpu_reset;
  assign bus.word_count   = r_count;
endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// tb_program_loader : randomized frames checked against a frame-level model
// of the loader (expected writes, final status and memory image).
module tb_program_loader;
  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  program_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  program_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  typedef struct {
    int         cyc;
    logic [3:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t        wq[$];
  wr_t        wfront;
  logic [7:0] exp_mem[DEPTH];
  logic [7:0] dut_mem[DEPTH];
  logic [7:0] fd[DEPTH];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] good_ck(input int n);
    logic [7:0] s = 8'h00;
    for (int i = 0; i < n; i++) s = s + fd[i];
    return 8'(~s + 8'd1);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle compare: invariants plus every write against the expected queue
  always @(negedge clk) begin
    chk("ready_vs_busy", 32'(bus.in_ready), 32'(bus.busy));
    chk("cpu_reset_vs_done", 32'(bus.cpu_reset), 32'(!bus.done));
    if (bus.mem_we === 1'b1) begin
      dut_mem[bus.mem_addr] = bus.mem_wdata;
      if (wq.size() == 0) begin
        chk("unexpected_write", 32'(bus.mem_we), 32'd0);
      end else begin
        wfront = wq.pop_front();
        chk("write_cycle", cyc, wfront.cyc);
        chk("write_addr", 32'(bus.mem_addr), 32'(wfront.addr));
        chk("write_data", 32'(bus.mem_wdata), 32'(wfront.data));
      end
    end else if (wq.size() != 0 && wq[0].cyc < cyc) begin
      chk("missing_write", 32'(bus.mem_we), 32'd1);
      void'(wq.pop_front());
    end
  end

  // mode 0: continuous, 1: random stalls, 2: valid low every other cycle
  task automatic send_byte(input logic [7:0] b, input int mode, output bit ok);
    int guard = 0;
    ok = 1'b0;
    if (mode == 2) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_data  = 8'($urandom);
    end
    while (!ok && guard < 100) begin
      @(negedge clk);
      guard++;
      if (mode == 1 && $urandom_range(0, 2) == 0) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
      end else begin
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        ok           = bus.in_ready;
      end
    end
    if (!ok) chk("accept_timeout", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic start_load(input bit with_valid);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.in_valid = with_valid;
    bus.in_data  = 8'($urandom);
    @(negedge clk);
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    chk("start_ready", 32'(bus.in_ready), 32'd1);
    chk("start_wc_clear", 32'(bus.word_count), 32'd0);
    chk("start_status", {30'd0, bus.done, bus.checksum_err}, 32'd0);
  endtask

  task automatic run_frame(input logic [7:0] hdr, input logic [7:0] ck, input int mode,
                           input bit poke_start, input bit start_valid);
    int         n;
    bit         hdr_ok;
    bit         ok;
    bit         exp_done;
    logic [7:0] sum;
    n      = int'(hdr[4:0]);
    hdr_ok = (hdr[7:5] == 3'b000) && (n >= 1) && (n <= DEPTH);
    start_load(start_valid);
    send_byte(hdr, mode, ok);
    exp_done = 1'b0;
    if (hdr_ok) begin
      sum = 8'h00;
      for (int i = 0; i < n; i++) begin
        if (poke_start && i == n / 2) begin
          @(negedge clk);
          bus.start    = 1'b1;
          bus.in_valid = 1'b0;
          @(negedge clk);
          bus.start = 1'b0;
          chk("busy_after_start", 32'(bus.busy), 32'd1);
        end
        send_byte(fd[i], mode, ok);
        if (ok) begin
          wq.push_back('{cyc + 1, 4'(i), fd[i]});
          exp_mem[i] = fd[i];
        end
        sum = sum + fd[i];
      end
      send_byte(ck, mode, ok);
      exp_done = (8'(sum + ck) == 8'h00);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("frame_done", 32'(bus.done), 32'(exp_done));
    chk("frame_err", 32'(bus.checksum_err), 32'(!exp_done));
    chk("frame_cpu_reset", 32'(bus.cpu_reset), 32'(!exp_done));
    chk("frame_busy", 32'(bus.busy), 32'd0);
    chk("frame_wc", 32'(bus.word_count), hdr_ok ? n : 0);
    chk("frame_writes_left", wq.size(), 32'd0);
    for (int i = 0; i < DEPTH; i++) chk("frame_mem", {20'd0, 4'(i), dut_mem[i]}, {20'd0, 4'(i), exp_mem[i]});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    for (int i = 0; i < DEPTH; i++) begin
      exp_mem[i] = 8'h00;
      dut_mem[i] = 8'h00;
    end

    #1 reset = 1'b1;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    chk("rst_word_count", 32'(bus.word_count), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err", 32'(bus.checksum_err), 32'd0);
    chk("rst_cpu_reset", 32'(bus.cpu_reset), 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Bytes offered in IDLE must be ignored
    repeat (3) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h05;
      chk("idle_ready", 32'(bus.in_ready), 32'd0);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("idle_wc", 32'(bus.word_count), 32'd0);

    // Directed good frame: 0x11+0x22+0x33 = 0x66, checksum 0x9A
    fd[0] = 8'h11; fd[1] = 8'h22; fd[2] = 8'h33;
    run_frame(8'h03, 8'h9A, 0, 1'b0, 1'b1);
    chk("lit_wc3", 32'(bus.word_count), 32'd3);
    chk("lit_done", 32'(bus.done), 32'd1);
    chk("lit_cpu_run", 32'(bus.cpu_reset), 32'd0);
    chk("lit_mem0", 32'(dut_mem[0]), 32'h11);
    chk("lit_mem1", 32'(dut_mem[1]), 32'h22);
    chk("lit_mem2", 32'(dut_mem[2]), 32'h33);

    // Same frame, wrong checksum
    run_frame(8'h03, 8'h9B, 0, 1'b0, 1'b0);
    chk("lit_err", 32'(bus.checksum_err), 32'd1);
    chk("lit_err_cpu_reset", 32'(bus.cpu_reset), 32'd1);

    // Bad headers
    run_frame(8'h00, 8'h00, 0, 1'b0, 1'b0);
    chk("lit_hdr0_wc", 32'(bus.word_count), 32'd0);
    run_frame(8'h11, 8'h00, 0, 1'b0, 1'b0);
    chk("lit_hdr17_err", 32'(bus.checksum_err), 32'd1);
    run_frame(8'hE3, 8'h00, 0, 1'b0, 1'b0);

    // Full 16-word frame with valid toggling
    for (int i = 0; i < DEPTH; i++) fd[i] = 8'($urandom);
    run_frame(8'h10, good_ck(16), 2, 1'b0, 1'b0);
    chk("lit_wc16", 32'(bus.word_count), 32'd16);

    // start pulsed mid-DATA is ignored
    for (int i = 0; i < DEPTH; i++) fd[i] = 8'($urandom);
    run_frame(8'h06, good_ck(6), 1, 1'b1, 1'b0);
    chk("lit_poke_done", 32'(bus.done), 32'd1);

    // From DONE, reset during the second data byte
    start_load(1'b0);
    fd[0] = 8'hA5;
    fd[1] = 8'h5A;
    send_byte(8'h02, 0, ok);
    send_byte(fd[0], 0, ok);
    if (ok) begin
      wq.push_back('{cyc + 1, 4'd0, fd[0]});
      exp_mem[0] = fd[0];
    end
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = fd[1];
    #1 reset = 1'b1;
    #1;
    chk("midrst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("midrst_cpu_reset", 32'(bus.cpu_reset), 32'd1);
    chk("midrst_done", 32'(bus.done), 32'd0);
    chk("midrst_ready", 32'(bus.in_ready), 32'd0);
    chk("midrst_wc", 32'(bus.word_count), 32'd0);
    repeat (3) @(negedge clk);
    bus.in_valid = 1'b0;
    reset        = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrst_no_writes", wq.size(), 32'd0);
    chk("midrst_mem1_kept", 32'(dut_mem[1]), 32'(exp_mem[1]));

    // Randomized frames
    repeat (30) begin
      int         n;
      int         kind;
      logic [7:0] hdr;
      logic [7:0] ck;
      n    = $urandom_range(1, DEPTH);
      kind = $urandom_range(0, 9);
      for (int i = 0; i < DEPTH; i++) fd[i] = 8'($urandom);
      hdr = 8'(n);
      if (kind == 0) hdr = 8'($urandom_range(17, 255));
      if (kind == 1) hdr = 8'h00;
      ck = (kind < 6) ? good_ck(n) : (good_ck(n) ^ 8'($urandom_range(1, 255)));
      run_frame(hdr, ck, $urandom_range(0, 2), ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
    end

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
